pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Controller that owns the program counter value and sequences instruction fetches from instruction memory over a req/ack handshake.
- Inserts branch and jump redirects, honours pipeline stalls, and delivers each fetched instruction with its PC to the decode stage.
- Sits between the PC register, branch/jump resolution logic and the instruction memory port.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- TIMEOUT_CYCLES, 16, WAIT-state cycles before abort. Used only with FETCH_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  decode not ready; no new fetch issued, delivered instruction held.
- BranchTaken  in  1  one-cycle pulse, redirect to BranchTarget.
- BranchTarget  in  32  branch destination.
- Jump  in  1  one-cycle pulse, redirect to JumpTarget.
- JumpTarget  in  32  jump destination.
- ImemReq  out  1  fetch request, registered.
- ImemAddr  out  32  fetch address, registered, equals current PC.
- ImemAck  in  1  memory returns ImemData this cycle.
- ImemData  in  32  instruction word.
- InstrValid  out  1  Instr/InstrPC valid.
- Instr  out  32  delivered instruction.
- InstrPC  out  32  address of Instr.
- PCResult  out  32  current PC.
- FetchError  out  1  sticky timeout flag. Tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - PC = RESET_PC; state = IDLE.
  - ImemReq = 0, ImemAddr = RESET_PC, InstrValid = 0, Instr = 0, InstrPC = 0.
  - redirect_pending = 0, FetchError = 0.
  - Asserting Reset mid-fetch drops ImemReq in the same cycle. A late ImemAck after reset release is ignored, because the block is in IDLE.
- States: IDLE, WAIT.
- IDLE:
  - Jump or BranchTaken asserted: PC <= target, stay IDLE. No request that cycle. Jump has priority over BranchTaken.
  - Otherwise, if !Stall and (!InstrValid or the held instruction is consumed this cycle): ImemReq <= 1, ImemAddr <= PC, go to WAIT.
  - ImemAck is ignored in IDLE.
- WAIT:
  - ImemReq and ImemAddr are held stable until ImemAck.
  - A redirect without ImemAck: latch the target, set redirect_pending.
  - A later redirect while pending overwrites the latched target, with Jump still winning within a cycle.
- ImemAck in WAIT with no redirect pending and none this cycle:
  - Next edge: Instr <= ImemData, InstrPC <= PC, InstrValid <= 1, PC <= PC + PC_STEP.
  - ImemReq <= 0, go to IDLE.
- ImemAck in WAIT with a redirect pending or arriving this cycle:
  - Data is discarded and InstrValid is not set.
  - PC <= pending target, or the same-cycle target (same-cycle wins).
  - Clear pending, go to IDLE.
- InstrValid handshake:
  - Consumed on any cycle with InstrValid=1 and Stall=0; it then clears next edge unless a new instruction is captured on that edge.
  - While Stall=1, InstrValid, Instr and InstrPC hold unchanged.
  - A redirect clears InstrValid next edge, flushing the wrong-path instruction.
- Throughput: 1 IDLE cycle + WAIT cycles (≥1) per instruction. Ack in the first WAIT cycle gives one instruction every 2 cycles.
- Arithmetic: PC + PC_STEP is modulo 2^32, so 32'hFFFFFFFC -> 32'h00000000. Targets are used unaligned, unmodified.
- PCResult always equals the internal PC register.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without ImemAck.
  - On reaching TIMEOUT_CYCLES: ImemReq <= 0, FetchError <= 1 (sticky until Reset), go to IDLE. PC is unchanged, so the same address is retried.
  - Any pending redirect is applied to PC at the abort.
- Undefined: no counter, WAIT is unbounded, FetchError constant 0.

Test Plan:
- Reset, then ack in the first WAIT cycle each time with data 0x11,0x22,0x33 -> ImemAddr 0,4,8; InstrValid pulses with InstrPC 0,4,8 and Instr 0x11,0x22,0x33; PCResult 0x0C.
- BranchTaken=1 with BranchTarget=0x100 in WAIT, ack 2 cycles later -> fetched word dropped, no InstrValid, next ImemAddr=0x100. Repeat with Jump=1 (JumpTarget=0x200) and Branch (0x100) in the same cycle -> next ImemAddr=0x200.
- Stall=1 while the instruction at PC 0x8 is valid for 5 cycles -> Instr/InstrPC held, ImemReq stays 0. Stall=0 -> request for 0xC next cycle.
- PC=0xFFFFFFFC, ack -> InstrPC=0xFFFFFFFC, next ImemAddr=0x00000000.
- Reset asserted during WAIT at PC 0x40 -> ImemReq=0 immediately, PCResult=RESET_PC; ack 1 cycle after release ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> FetchError=1 after 4 WAIT cycles, retry at the same address, ack -> normal delivery, FetchError stays 1.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter and sequences instruction fetches over a req/ack
//   handshake. Branch/jump redirects are applied directly in IDLE, or latched
//   and applied when the outstanding fetch completes. Any fetch that completes
//   while a redirect is pending (or arriving) is discarded.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     When defined, a fetch that waits TIMEOUT_CYCLES cycles without an ack is
//     aborted. FetchError is then set and stays set until Reset. The same PC is
//     retried.
//     When undefined, WAIT is unbounded and FetchError is tied to 0.
//
// Ports
//   Clk, Reset                   clock (rising edge), asynchronous active-high reset
//   Stall                        decode not ready: no new fetch, output held
//   BranchTaken, BranchTarget    one-cycle branch redirect
//   Jump, JumpTarget             one-cycle jump redirect (wins over branch)
//   ImemReq, ImemAddr            registered fetch request / address
//   ImemAck, ImemData            memory response
//   InstrValid, Instr, InstrPC   delivered instruction and its address
//   PCResult                     current PC register
//   FetchError                   sticky fetch-timeout flag
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned PC_STEP        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCResult,
    output logic        FetchError
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      r_state,      w_state_d;
    logic [31:0] r_pc,         w_pc_d;
    logic        r_req,        w_req_d;
    logic [31:0] r_addr,       w_addr_d;
    logic        r_valid,      w_valid_d;
    logic [31:0] r_instr,      w_instr_d;
    logic [31:0] r_instr_pc,   w_instr_pc_d;
    logic        r_pending,    w_pending_d;
    logic [31:0] r_redir_tgt,  w_redir_tgt_d;

    logic        w_redir;
    logic [31:0] w_redir_tgt;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic             r_error,    w_error_d;
`endif

    // Jump wins over branch when both arrive in the same cycle.
    assign w_redir     = Jump | BranchTaken;
    assign w_redir_tgt = Jump ? JumpTarget : BranchTarget;

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_req_d       = r_req;
        w_addr_d      = r_addr;
        w_valid_d     = r_valid;
        w_instr_d     = r_instr;
        w_instr_pc_d  = r_instr_pc;
        w_pending_d   = r_pending;
        w_redir_tgt_d = r_redir_tgt;
`ifdef FETCH_TIMEOUT_EN
        w_wait_cnt_d  = r_wait_cnt;
        w_error_d     = r_error;
`endif

        // Consumed instruction drops; a redirect flushes the wrong-path one.
        if (r_valid && !Stall) w_valid_d = 1'b0;
        if (w_redir)           w_valid_d = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_redir) begin
                    w_pc_d = w_redir_tgt;
                end else if (!Stall) begin
                    // Not stalled implies the held instruction (if any) is consumed.
                    w_req_d   = 1'b1;
                    w_addr_d  = r_pc;
                    w_state_d = StWait;
`ifdef FETCH_TIMEOUT_EN
                    w_wait_cnt_d = '0;
`endif
                end
            end
            StWait: begin
                if (ImemAck) begin
                    w_req_d     = 1'b0;
                    w_state_d   = StIdle;
                    w_pending_d = 1'b0;
                    if (w_redir) begin
                        w_pc_d = w_redir_tgt;
                    end else if (r_pending) begin
                        w_pc_d = r_redir_tgt;
                    end else begin
                        w_instr_d    = ImemData;
                        w_instr_pc_d = r_pc;
                        w_valid_d    = 1'b1;
                        w_pc_d       = r_pc + 32'(PC_STEP);
                    end
                end else begin
                    if (w_redir) begin
                        w_pending_d   = 1'b1;
                        w_redir_tgt_d = w_redir_tgt;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: PC keeps the failed address unless a redirect is due.
                        w_req_d     = 1'b0;
                        w_error_d   = 1'b1;
                        w_state_d   = StIdle;
                        w_pending_d = 1'b0;
                        if (w_redir) begin
                            w_pc_d = w_redir_tgt;
                        end else if (r_pending) begin
                            w_pc_d = r_redir_tgt;
                        end
                    end else begin
                        w_wait_cnt_d = r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_valid     <= 1'b0;
            r_instr     <= 32'h0;
            r_instr_pc  <= 32'h0;
            r_pending   <= 1'b0;
            r_redir_tgt <= 32'h0;
        end else begin
            r_state     <= w_state_d;
            r_pc        <= w_pc_d;
            r_req       <= w_req_d;
            r_addr      <= w_addr_d;
            r_valid     <= w_valid_d;
            r_instr     <= w_instr_d;
            r_instr_pc  <= w_instr_pc_d;
            r_pending   <= w_pending_d;
            r_redir_tgt <= w_redir_tgt_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
            r_error    <= w_error_d;
        end
    end
    assign FetchError = r_error;
`else
    assign FetchError = 1'b0;
`endif

    assign ImemReq    = r_req;
    assign ImemAddr   = r_addr;
    assign InstrValid = r_valid;
    assign Instr      = r_instr;
    assign InstrPC    = r_instr_pc;
    assign PCResult   = r_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'h0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = 32'h0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PCResult;
    logic        FetchError;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pc_fetch_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .PC_STEP       (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemData    (ImemData),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .InstrPC     (InstrPC),
        .PCResult    (PCResult),
        .FetchError  (FetchError)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(logic stall, logic br, logic [31:0] bt, logic jmp,
                                logic [31:0] jt, logic ack, logic [31:0] data,
                                logic req, logic [31:0] addr, logic valid,
                                logic [31:0] instr, logic [31:0] ipc, logic [31:0] pc);
        vec_t v;
        v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.ack = ack; v.data = data; v.req = req; v.addr = addr; v.valid = valid;
        v.instr = instr; v.ipc = ipc; v.pc = pc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic stall, logic br, logic [31:0] bt, logic jmp,
                         logic [31:0] jt, logic ack, logic [31:0] data);
        Stall = stall; BranchTaken = br; BranchTarget = bt;
        Jump = jmp; JumpTarget = jt; ImemAck = ack; ImemData = data;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(string tag, logic req, logic [31:0] addr, logic valid,
                             logic [31:0] instr, logic [31:0] ipc, logic [31:0] pc,
                             logic err);
        check({tag, ".req"},   {31'h0, ImemReq},    {31'h0, req});
        check({tag, ".addr"},  ImemAddr,            addr);
        check({tag, ".valid"}, {31'h0, InstrValid}, {31'h0, valid});
        check({tag, ".instr"}, Instr,               instr);
        check({tag, ".ipc"},   InstrPC,             ipc);
        check({tag, ".pc"},    PCResult,            pc);
        check({tag, ".err"},   {31'h0, FetchError}, {31'h0, err});
    endtask

    initial begin
        // Sequential fetches, ack in the first WAIT cycle.
        vecs[0]  = mk(0,0,0,0,0,0,0,              1,32'h0,0,32'h0,32'h0,32'h0);
        vecs[1]  = mk(0,0,0,0,0,1,32'h11,         0,32'h0,1,32'h11,32'h0,32'h4);
        vecs[2]  = mk(0,0,0,0,0,0,0,              1,32'h4,0,32'h11,32'h0,32'h4);
        vecs[3]  = mk(0,0,0,0,0,1,32'h22,         0,32'h4,1,32'h22,32'h4,32'h8);
        vecs[4]  = mk(0,0,0,0,0,0,0,              1,32'h8,0,32'h22,32'h4,32'h8);
        vecs[5]  = mk(0,0,0,0,0,1,32'h33,         0,32'h8,1,32'h33,32'h8,32'hC);
        // Stall holds the instruction at 0x8 for five cycles.
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(1,0,0,0,0,0,0,           0,32'h8,1,32'h33,32'h8,32'hC);
        vecs[11] = mk(0,0,0,0,0,0,0,              1,32'hC,0,32'h33,32'h8,32'hC);
        // Branch in WAIT, ack two cycles later: data dropped.
        vecs[12] = mk(0,1,32'h100,0,0,0,0,        1,32'hC,0,32'h33,32'h8,32'hC);
        vecs[13] = mk(0,0,0,0,0,0,0,              1,32'hC,0,32'h33,32'h8,32'hC);
        vecs[14] = mk(0,0,0,0,0,1,32'hDEAD,       0,32'hC,0,32'h33,32'h8,32'h100);
        vecs[15] = mk(0,0,0,0,0,0,0,              1,32'h100,0,32'h33,32'h8,32'h100);
        // Jump and branch together: jump wins.
        vecs[16] = mk(0,1,32'h100,1,32'h200,0,0,  1,32'h100,0,32'h33,32'h8,32'h100);
        vecs[17] = mk(0,0,0,0,0,1,32'hBEEF,       0,32'h100,0,32'h33,32'h8,32'h200);
        vecs[18] = mk(0,0,0,0,0,0,0,              1,32'h200,0,32'h33,32'h8,32'h200);
        // Redirect arriving with the ack.
        vecs[19] = mk(0,1,32'h300,0,0,1,32'h55,   0,32'h200,0,32'h33,32'h8,32'h300);
        // Redirect in IDLE, then PC wrap-around.
        vecs[20] = mk(0,0,0,1,32'hFFFFFFFC,0,0,   0,32'h200,0,32'h33,32'h8,32'hFFFFFFFC);
        vecs[21] = mk(0,0,0,0,0,0,0,              1,32'hFFFFFFFC,0,32'h33,32'h8,32'hFFFFFFFC);
        vecs[22] = mk(0,0,0,0,0,1,32'h77,         0,32'hFFFFFFFC,1,32'h77,32'hFFFFFFFC,32'h0);
        vecs[23] = mk(0,0,0,0,0,0,0,              1,32'h0,0,32'h77,32'hFFFFFFFC,32'h0);
        vecs[24] = mk(0,0,0,0,0,1,32'h88,         0,32'h0,1,32'h88,32'h0,32'h4);
        // Redirect flushes a valid, stalled instruction.
        vecs[25] = mk(1,1,32'h40,0,0,0,0,         0,32'h0,0,32'h88,32'h0,32'h40);
        vecs[26] = mk(0,0,0,0,0,0,0,              1,32'h40,0,32'h88,32'h0,32'h40);

        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt,
                  vecs[i].ack, vecs[i].data);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                      vecs[i].instr, vecs[i].ipc, vecs[i].pc, 0);
        end

        // Reset during WAIT at 0x40 drops the request immediately.
        drive(0,0,0,0,0,0,0);
        #2;
        Reset = 1'b1;
        #1;
        check_all("rst_mid", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        step();
        Reset = 1'b0;
        // Late ack one cycle after release lands in IDLE and is ignored.
        drive(1,0,0,0,0,1,32'h99);
        step();
        check_all("late_ack", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        drive(0,0,0,0,0,0,0);
        step();
        check_all("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        drive(0,0,0,0,0,1,32'hA5);
        step();
        check_all("post_rst_ack", 0, 32'h0, 1, 32'hA5, 32'h0, 32'h4, 0);

        drive(0,0,0,0,0,0,0);
        step();
        check_all("to_req", 1, 32'h4, 0, 32'hA5, 32'h0, 32'h4, 0);
`ifdef FETCH_TIMEOUT_EN
        // Three waiting cycles keep the request, the fourth aborts.
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("to_wait%0d", i), 1, 32'h4, 0, 32'hA5, 32'h0, 32'h4, 0);
        end
        step();
        check_all("to_abort", 0, 32'h4, 0, 32'hA5, 32'h0, 32'h4, 1);
        step();
        check_all("to_retry", 1, 32'h4, 0, 32'hA5, 32'h0, 32'h4, 1);
        drive(0,0,0,0,0,1,32'hC3);
        step();
        check_all("to_deliver", 0, 32'h4, 1, 32'hC3, 32'h4, 32'h8, 1);
`else
        // Without the timeout WAIT is unbounded.
        for (int i = 0; i < 20; i++) begin
            step();
            check_all($sformatf("nto_wait%0d", i), 1, 32'h4, 0, 32'hA5, 32'h0, 32'h4, 0);
        end
        drive(0,0,0,0,0,1,32'hC3);
        step();
        check_all("nto_deliver", 0, 32'h4, 1, 32'hC3, 32'h4, 32'h8, 0);
`endif
        drive(0,0,0,0,0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
